// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transaction sequencer.
// Contents: FSM state encoding, SPI word width, response FIFO entry layout
// (err flag present only when SPI_SEQ_TIMEOUT_EN is defined), clog2 helper.
package spi_seq_pkg;

    localparam int unsigned SPI_WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4
    } seq_state_e;

`ifdef SPI_SEQ_TIMEOUT_EN
    typedef struct packed {
        logic                  err;
        logic [SPI_WORD_W-1:0] data;
    } rsp_entry_t;
`else
    typedef struct packed {
        logic [SPI_WORD_W-1:0] data;
    } rsp_entry_t;
`endif

    localparam int unsigned RSP_ENTRY_W = $bits(rsp_entry_t);

    // Ceiling log2 for elaboration-time width math.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO, async active-low reset, power-of-2 depth.
// Ports: clk, rst_n; write side wr_valid/wr_data/wr_ready (ready = not full);
// read side rd_valid/rd_data/rd_ready (rd_data is the head entry, popped on valid&ready).
module spi_seq_fifo
    import spi_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
    assign wr_ready = (count != CW'(DEPTH));
    assign rd_valid = (count != CW'(0));
    assign rd_data  = mem[rd_ptr];
    assign do_wr    = wr_valid & wr_ready;
    assign do_rd    = rd_valid & rd_ready;

    // Storage, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Command sequencer in front of a 32-bit SPI transmitter: one frame per command word,
// received word captured into a response FIFO, minimum CS-high gap between frames.
// Ports: clk, rst (async active-low); cmd_valid/cmd_data/cmd_ready command in;
// rsp_valid/rsp_data/rsp_err/rsp_ready response out; spi_rst_n/spi_send_data drive the
// transmitter, spi_send_complete/spi_recv_data come back from it; busy = frame in progress.
// Macro SPI_SEQ_TIMEOUT_EN adds a RUN-state watchdog that aborts a frame after
// TIMEOUT_CYCLES and returns an err=1, data=0 response.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned RSP_DEPTH      = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [SPI_WORD_W-1:0] cmd_data,
    output logic                  cmd_ready,
    output logic                  rsp_valid,
    output logic [SPI_WORD_W-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic                  spi_rst_n,
    output logic [SPI_WORD_W-1:0] spi_send_data,
    input  logic                  spi_send_complete,
    input  logic [SPI_WORD_W-1:0] spi_recv_data,
    output logic                  busy
);

    localparam int unsigned GAP_W = clog2(GAP_CYCLES + 1);

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CMD_DEPTH < 2 || RSP_DEPTH < 2) begin : g_bad_params
        $error("spi_txn_sequencer: illegal parameter values");
    end

    seq_state_e            state_q;
    seq_state_e            state_d;
    logic                  cmd_pop;
    logic                  cmd_head_valid;
    logic [SPI_WORD_W-1:0] cmd_head;
    logic                  rsp_push;
    logic                  rsp_wr_ready;
    rsp_entry_t            rsp_wr_entry;
    rsp_entry_t            rsp_rd_entry;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic                  gap_done;
    logic                  spi_rst_n_d;
    logic                  busy_d;
    logic                  timeout_c;
    logic                  abort_c;

    spi_seq_fifo #(.WIDTH(SPI_WORD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .wr_valid (cmd_valid),
        .wr_data  (cmd_data),
        .wr_ready (cmd_ready),
        .rd_valid (cmd_head_valid),
        .rd_data  (cmd_head),
        .rd_ready (cmd_pop)
    );

    spi_seq_fifo #(.WIDTH(RSP_ENTRY_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .wr_valid (rsp_push),
        .wr_data  (rsp_wr_entry),
        .wr_ready (rsp_wr_ready),
        .rd_valid (rsp_valid),
        .rd_data  (rsp_rd_entry),
        .rd_ready (rsp_ready)
    );

    assign rsp_data = rsp_rd_entry.data;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            abort_q;

    // Watchdog runs only in RUN; held at zero elsewhere so it restarts on each RUN entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  wd_cnt_q <= '0;
        else if (state_q != ST_RUN) wd_cnt_q <= '0;
        else                       wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end

    // Completion wins over expiry in the same cycle.
    assign timeout_c = (state_q == ST_RUN) && !spi_send_complete &&
                       (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Marks the CAPTURE in progress as an aborted frame until its response is pushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           abort_q <= 1'b0;
        else if (timeout_c) abort_q <= 1'b1;
        else if (rsp_push)  abort_q <= 1'b0;
    end

    assign abort_c            = abort_q | timeout_c;
    assign rsp_wr_entry.err  = abort_q;
    assign rsp_wr_entry.data = abort_q ? SPI_WORD_W'(0) : spi_recv_data;
    assign rsp_err           = rsp_rd_entry.err;
`else
    assign timeout_c          = 1'b0;
    assign abort_c            = 1'b0;
    assign rsp_wr_entry.data = spi_recv_data;
    assign rsp_err           = 1'b0;
`endif

    // GAP dwell counter, cleared whenever outside GAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   gap_cnt_q <= '0;
        else if (state_q != ST_GAP) gap_cnt_q <= '0;
        else                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
    end

    assign gap_done = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            spi_rst_n     <= 1'b0;
            busy          <= 1'b0;
            spi_send_data <= '0;
        end else begin
            state_q   <= state_d;
            spi_rst_n <= spi_rst_n_d;
            busy      <= busy_d;
            if (cmd_pop) spi_send_data <= cmd_head;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_head_valid) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_RUN;
            ST_RUN:     if (spi_send_complete || timeout_c) state_d = ST_CAPTURE;
            ST_CAPTURE: if (rsp_wr_ready) state_d = ST_GAP;
            ST_GAP:     if (gap_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FIFO strobes from the current state; transmitter reset and busy from the next state.
    always_comb begin
        cmd_pop     = 1'b0;
        rsp_push    = 1'b0;
        spi_rst_n_d = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE:    cmd_pop  = cmd_head_valid;
            ST_CAPTURE: rsp_push = rsp_wr_ready;
            default:    ;
        endcase
        case (state_d)
            ST_RUN:     spi_rst_n_d = 1'b1;
            ST_CAPTURE: spi_rst_n_d = !abort_c;
            default:    spi_rst_n_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench: sequencer + behavioural SPI transmitter + SPI slave.
// The slave returns slave_seed + frame_no for each frame and records MOSI.
module tb_spi_txn_sequencer;

    localparam int unsigned GAP = 2;
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int unsigned TMO = 50;
`else
    localparam int unsigned TMO = 256;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready = 1'b0;
    logic        spi_rst_n;
    logic [31:0] spi_send_data;
    logic        spi_send_complete;
    logic [31:0] spi_recv_data;
    logic        busy;

    always #5 clk = ~clk;

    spi_txn_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .spi_rst_n(spi_rst_n), .spi_send_data(spi_send_data), .spi_send_complete(spi_send_complete),
        .spi_recv_data(spi_recv_data), .busy(busy)
    );

    // Transmitter + slave model: 2 clk per SPI bit, MSB first, sticky complete.
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        complete = 1'b0;
    logic [5:0]  bcnt = '0;
    logic [31:0] tx_sh = '0, rx_sh = '0, sl_tx = '0, sl_rx = '0;
    logic        stall_en = 1'b0;
    logic [31:0] slave_seed = '0;
    int          frame_no = 0;

    assign spi_send_complete = complete;
    assign spi_recv_data     = rx_sh;

    always @(posedge clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            sclk <= 1'b0; cs_n <= 1'b1; complete <= 1'b0; bcnt <= '0;
            tx_sh <= spi_send_data; rx_sh <= '0;
            sl_tx <= slave_seed + 32'(frame_no); sl_rx <= '0;
        end else if (!complete) begin
            cs_n <= 1'b0;
            bcnt <= bcnt + 6'd1;
            if (!bcnt[0]) begin
                sclk  <= 1'b1;
                rx_sh <= {rx_sh[30:0], sl_tx[31]};
                sl_rx <= {sl_rx[30:0], tx_sh[31]};
            end else begin
                sclk  <= 1'b0;
                tx_sh <= tx_sh << 1;
                sl_tx <= sl_tx << 1;
                if (bcnt == 6'd63 && !stall_en) begin
                    complete <= 1'b1;
                    cs_n     <= 1'b1;
                end
            end
        end
    end

    // Logs: MOSI word per completed frame, popped responses, CS-high run lengths.
    logic [31:0] mosi_log [128];
    int          mosi_n = 0;
    logic [31:0] rsp_log [128];
    logic        err_log [128];
    int          rsp_n = 0;
    int          gap_log [128];
    int          gap_n = 0;
    int          hi_cnt = 0;

    always @(posedge clk) begin
        if (spi_rst_n && !complete && !stall_en && bcnt == 6'd63 && mosi_n < 128) begin
            mosi_log[mosi_n] <= sl_rx;
            mosi_n           <= mosi_n + 1;
            frame_no         <= frame_no + 1;
        end
        if (rst && rsp_valid && rsp_ready && rsp_n < 128) begin
            rsp_log[rsp_n] <= rsp_data;
            err_log[rsp_n] <= rsp_err;
            rsp_n          <= rsp_n + 1;
        end
        if (cs_n) hi_cnt <= hi_cnt + 1;
        else if (hi_cnt != 0) begin
            if (gap_n < 128) gap_log[gap_n] <= hi_cnt;
            gap_n  <= gap_n + 1;
            hi_cnt <= 0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic push_cmd(input logic [31:0] d);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (t >= 2000) begin n_fail++; $display("FAIL push_accept: cmd %h not accepted within 2000 cycles", d); end
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int t;
        t = 0;
        while (rsp_n < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rsp_n < target) begin n_fail++; $display("FAIL rsp_timeout: got %0d responses, need %0d", rsp_n, target); end
    endtask

    task automatic wait_run(input int budget);
        int t;
        t = 0;
        while (!spi_rst_n && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!spi_rst_n) begin n_fail++; $display("FAIL run_timeout: spi_rst_n still 0 after %0d cycles", budget); end
    endtask

    task automatic wait_idle_cycle(input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (busy) begin n_fail++; $display("FAIL idle_timeout: busy still 1 after %0d cycles", budget); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (spi_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_spi_rst_n: got %b want 0", spi_rst_n); end
        n_checks++; if (spi_send_data !== 32'h0) begin n_fail++; $display("FAIL reset_send_data: got %h want 0", spi_send_data); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || spi_rst_n !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy %b spi_rst_n %b want 0 0", busy, spi_rst_n); end
    endtask

    task automatic test_single();
        int br, bm;
        rsp_ready  = 1'b1;
        slave_seed = 32'h1234_5678 - 32'(frame_no);
        br = rsp_n; bm = mosi_n;
        cmd_valid = 1'b1; cmd_data = 32'hA5A5_0F0F;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_pop_cycle_busy: got %b want 0", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || spi_rst_n !== 1'b0) begin n_fail++; $display("FAIL single_load: busy %b spi_rst_n %b want 1 0", busy, spi_rst_n); end
        n_checks++; if (spi_send_data !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_send_data: got %h want a5a50f0f", spi_send_data); end
        @(negedge clk);
        n_checks++; if (spi_rst_n !== 1'b1) begin n_fail++; $display("FAIL single_run: spi_rst_n %b want 1", spi_rst_n); end
        wait_rsp(br + 1, 300);
        n_checks++; if (rsp_log[br] !== 32'h1234_5678) begin n_fail++; $display("FAIL single_rsp_data: got %h want 12345678", rsp_log[br]); end
        n_checks++; if (err_log[br] !== 1'b0) begin n_fail++; $display("FAIL single_rsp_err: got %b want 0", err_log[br]); end
        n_checks++; if (mosi_log[bm] !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_mosi: got %h want a5a50f0f", mosi_log[bm]); end
        repeat (10) @(negedge clk);
        n_checks++; if (spi_send_data !== 32'hA5A5_0F0F || busy !== 1'b0) begin n_fail++; $display("FAIL single_hold: send_data %h busy %b want a5a50f0f 0", spi_send_data, busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cmds [5];
        int br, bm, bg, fn0;
        for (int i = 0; i < 5; i++) cmds[i] = 32'h1111_0000 + 32'(i * 32'h0101_0011);
        slave_seed = 32'hC0DE_0000;
        rsp_ready = 1'b1;
        br = rsp_n; bm = mosi_n; bg = gap_n; fn0 = frame_no;
        push_cmd(cmds[0]);
        wait_run(20);
        for (int i = 1; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_data = cmds[i];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", cmd_ready); end
        cmd_valid = 1'b1; cmd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_still_full: got %b want 0", cmd_ready); end
        wait_rsp(br + 5, 1500);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rsp_log[br + i] !== slave_seed + 32'(fn0 + i)) begin n_fail++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rsp_log[br + i], slave_seed + 32'(fn0 + i)); end
            n_checks++; if (mosi_log[bm + i] !== cmds[i]) begin n_fail++; $display("FAIL b2b_mosi%0d: got %h want %h", i, mosi_log[bm + i], cmds[i]); end
        end
        n_checks++; if (gap_n < bg + 5) begin n_fail++; $display("FAIL b2b_gap_count: got %0d want >= %0d", gap_n, bg + 5); end
        for (int j = 1; j < 5; j++) begin
            n_checks++; if (gap_log[bg + j] < int'(GAP + 1)) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want >= %0d", j, gap_log[bg + j], GAP + 1); end
        end
        repeat (200) @(negedge clk);
        n_checks++; if (rsp_n !== br + 5) begin n_fail++; $display("FAIL b2b_extra_frame: got %0d responses want %0d", rsp_n - br, 5); end
    endtask

    task automatic test_rsp_stall();
        logic [31:0] cmds [6];
        int br, fn0, t;
        for (int i = 0; i < 6; i++) cmds[i] = 32'h5A00_0000 + 32'(i * 32'h0003_0007);
        slave_seed = 32'h7700_0000;
        rsp_ready = 1'b0;
        br = rsp_n; fn0 = frame_no;
        for (int i = 0; i < 6; i++) push_cmd(cmds[i]);
        t = 0;
        while (frame_no < fn0 + 5 && t < 1500) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        n_checks++; if (frame_no !== fn0 + 5) begin n_fail++; $display("FAIL stall_frames: got %0d frames want 5", frame_no - fn0); end
        n_checks++; if (busy !== 1'b1 || spi_rst_n !== 1'b1) begin n_fail++; $display("FAIL stall_capture: busy %b spi_rst_n %b want 1 1", busy, spi_rst_n); end
        n_checks++; if (spi_send_data !== cmds[4]) begin n_fail++; $display("FAIL stall_send_data: got %h want %h", spi_send_data, cmds[4]); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== slave_seed + 32'(fn0)) begin n_fail++; $display("FAIL stall_head: valid %b data %h want 1 %h", rsp_valid, rsp_data, slave_seed + 32'(fn0)); end
        rsp_ready = 1'b1;
        wait_rsp(br + 6, 1000);
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (rsp_log[br + i] !== slave_seed + 32'(fn0 + i)) begin n_fail++; $display("FAIL stall_rsp%0d: got %h want %h", i, rsp_log[br + i], slave_seed + 32'(fn0 + i)); end
        end
        repeat (50) @(negedge clk);
        n_checks++; if (rsp_n !== br + 6) begin n_fail++; $display("FAIL stall_dup: got %0d responses want 6", rsp_n - br); end
    endtask

    task automatic test_mid_reset();
        int fn0, br, bm, t;
        slave_seed = 32'h0BAD_0000;
        rsp_ready = 1'b1;
        fn0 = frame_no;
        push_cmd(32'hD000_0001);
        wait_run(20);
        push_cmd(32'hD000_0002);
        push_cmd(32'hD000_0003);
        t = 0;
        while (!(frame_no == fn0 + 1 && spi_rst_n) && t < 500) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (spi_rst_n !== 1'b0 || cs_n !== 1'b1) begin n_fail++; $display("FAIL midrst_spi: spi_rst_n %b cs_n %b want 0 1", spi_rst_n, cs_n); end
        n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: cmd_ready %b rsp_valid %b busy %b want 1 0 0", cmd_ready, rsp_valid, busy); end
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flushed: busy %b rsp_valid %b want 0 0", busy, rsp_valid); end
        br = rsp_n; bm = mosi_n; fn0 = frame_no;
        push_cmd(32'hE1E2_E3E4);
        wait_rsp(br + 1, 300);
        n_checks++; if (rsp_log[br] !== slave_seed + 32'(fn0) || err_log[br] !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp: got %h err %b want %h 0", rsp_log[br], err_log[br], slave_seed + 32'(fn0)); end
        n_checks++; if (mosi_log[bm] !== 32'hE1E2_E3E4) begin n_fail++; $display("FAIL midrst_mosi: got %h want e1e2e3e4", mosi_log[bm]); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_same_cycle();
        logic [31:0] x [6];
        int br, bm;
        for (int i = 0; i < 6; i++) x[i] = 32'h3C00_0000 + 32'(i * 32'h0011_0101);
        slave_seed = 32'h4400_0000;
        rsp_ready = 1'b1;
        br = rsp_n; bm = mosi_n;
        push_cmd(x[0]);
        wait_run(20);
        for (int i = 1; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_data = x[i];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_idle_cycle(300);
        cmd_valid = 1'b1; cmd_data = x[4];
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_at3: cmd_ready %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_data = x[5];
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL same_cycle_fill: cmd_ready %b want 0", cmd_ready); end
        wait_idle_cycle(300);
        cmd_valid = 1'b1; cmd_data = 32'hBAD0_BAD0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_full_pop: cmd_ready %b want 1", cmd_ready); end
        wait_rsp(br + 6, 1200);
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (mosi_log[bm + i] !== x[i]) begin n_fail++; $display("FAIL same_cycle_mosi%0d: got %h want %h", i, mosi_log[bm + i], x[i]); end
        end
        repeat (200) @(negedge clk);
        n_checks++; if (mosi_n !== bm + 6) begin n_fail++; $display("FAIL same_cycle_rejected: got %0d frames want 6", mosi_n - bm); end
    endtask

`ifdef SPI_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int br, fn0;
        rsp_ready = 1'b1;
        stall_en = 1'b1;
        br = rsp_n;
        push_cmd(32'h7777_0001);
        wait_rsp(br + 1, 300);
        n_checks++; if (err_log[br] !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err_log[br]); end
        n_checks++; if (rsp_log[br] !== 32'h0) begin n_fail++; $display("FAIL timeout_data: got %h want 0", rsp_log[br]); end
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || spi_rst_n !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy %b spi_rst_n %b want 0 0", busy, spi_rst_n); end
        stall_en = 1'b0;
        slave_seed = 32'h9900_0000;
        fn0 = frame_no;
        push_cmd(32'h7777_0002);
        wait_rsp(br + 2, 300);
        n_checks++; if (err_log[br + 1] !== 1'b0 || rsp_log[br + 1] !== slave_seed + 32'(fn0)) begin n_fail++; $display("FAIL timeout_next: err %b data %h want 0 %h", err_log[br + 1], rsp_log[br + 1], slave_seed + 32'(fn0)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rsp_stall();
        test_mid_reset();
        test_same_cycle();
`ifdef SPI_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
